// File: rtl/md_pkg.sv
// Shared op codes, SPECIAL funct codes, FSM states and default latencies
// for the mul/div issue controller.
package md_pkg;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;
    localparam int DEF_CNT_W       = 4;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    localparam logic [5:0] OPC_SPECIAL = 6'h00;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN_MUL = 2'd1,
        ST_RUN_DIV = 2'd2
    } mdState_e;

endpackage

// File: rtl/md_issue_ctrl_if.sv
// Controller-to-mul/div-unit bus: Start/Op/operands out, Busy back.
interface md_issue_ctrl_if;

    logic        md_start;
    logic [3:0]  md_op;
    logic [31:0] md_rdata1;
    logic [31:0] md_rdata2;
    logic        md_busy;

    modport master (
        output md_start,
        output md_op,
        output md_rdata1,
        output md_rdata2,
        input  md_busy
    );

    modport slave (
        input  md_start,
        input  md_op,
        input  md_rdata1,
        input  md_rdata2,
        output md_busy
    );

endinterface

// File: rtl/md_decode.sv
// Combinational classifier for E-stage SPECIAL instructions that touch the
// mul/div unit or HI/LO.
module md_decode
    import md_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output logic       o_isLong,
    output logic       o_isMove,
    output logic       o_isRead,
    output logic [3:0] o_opCode
);

    always_comb begin
        o_isLong = 1'b0;
        o_isMove = 1'b0;
        o_isRead = 1'b0;
        o_opCode = OP_NONE;
        if (i_opcode == OPC_SPECIAL) begin
            case (i_funct)
                FN_MULT:  begin o_isLong = 1'b1; o_opCode = OP_MULT;  end
                FN_MULTU: begin o_isLong = 1'b1; o_opCode = OP_MULTU; end
                FN_DIV:   begin o_isLong = 1'b1; o_opCode = OP_DIV;   end
                FN_DIVU:  begin o_isLong = 1'b1; o_opCode = OP_DIVU;  end
                FN_MTHI:  begin o_isMove = 1'b1; o_opCode = OP_MTHI;  end
                FN_MTLO:  begin o_isMove = 1'b1; o_opCode = OP_MTLO;  end
                FN_MFHI:  o_isRead = 1'b1;
                FN_MFLO:  o_isRead = 1'b1;
                default:  ;
            endcase
        end
    end

endmodule

// File: rtl/md_issue_ctrl.sv
// E-stage issue controller for the mul/div unit: holds Start/Op/operands for
// the op latency and stalls HI/LO users. Optional stall counter: MD_STALL_PERF_EN.
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
)
(
    input  logic           clk,
    input  logic           reset,
    input  logic           e_valid,
    input  logic           e_kill,
    input  logic [5:0]     e_opcode,
    input  logic [5:0]     e_funct,
    input  logic [31:0]    e_rs_val,
    input  logic [31:0]    e_rt_val,
    md_issue_ctrl_if.master mdIf,
    output logic           stall_e
`ifdef MD_STALL_PERF_EN
    ,
    output logic [31:0]    stall_cnt
`endif
);

    mdState_e         r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_start;
    logic [3:0]       r_op;
    logic [31:0]      r_rdata1;
    logic [31:0]      r_rdata2;

    logic             w_isLong;
    logic             w_isMove;
    logic             w_isRead;
    logic [3:0]       w_opCode;
    logic             w_busyAny;
    logic             w_live;
    logic             w_issue;
    logic             w_runDone;

    md_decode u_decode (
        .i_opcode (e_opcode),
        .i_funct  (e_funct),
        .o_isLong (w_isLong),
        .o_isMove (w_isMove),
        .o_isRead (w_isRead),
        .o_opCode (w_opCode)
    );

    assign w_busyAny = (r_state != ST_IDLE) | mdIf.md_busy;
    assign w_live    = e_valid & ~e_kill;
    assign w_issue   = w_live & ~w_busyAny;
    // Gated by reset so the pipeline never sees a stall while reset is held.
    assign stall_e   = reset & w_live & w_busyAny & (w_isLong | w_isMove | w_isRead);

    assign w_runDone = ((r_state == ST_RUN_MUL) && (r_cnt == CNT_W'(MULT_CYCLES))) ||
                       ((r_state == ST_RUN_DIV) && (r_cnt == CNT_W'(DIV_CYCLES)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_start  <= 1'b0;
            r_op     <= OP_NONE;
            r_rdata1 <= '0;
            r_rdata2 <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_start <= 1'b0;
                    r_op    <= OP_NONE;
                    r_cnt   <= '0;
                    if (w_issue && w_isLong) begin
                        r_start  <= 1'b1;
                        r_op     <= w_opCode;
                        r_rdata1 <= e_rs_val;
                        r_rdata2 <= e_rt_val;
                        r_cnt    <= CNT_W'(1);
                        r_state  <= ((w_opCode == OP_MULT) || (w_opCode == OP_MULTU)) ?
                                    ST_RUN_MUL : ST_RUN_DIV;
                    end else if (w_issue && w_isMove) begin
                        // Move-to ops are a single-cycle Op with no Start pulse.
                        r_op <= w_opCode;
                        if (w_opCode == OP_MTHI) begin
                            r_rdata1 <= e_rs_val;
                        end else begin
                            r_rdata2 <= e_rs_val;
                        end
                    end
                end
                ST_RUN_MUL, ST_RUN_DIV: begin
                    if (w_runDone) begin
                        r_start <= 1'b0;
                        r_op    <= OP_NONE;
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_start <= 1'b0;
                    r_op    <= OP_NONE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign mdIf.md_start  = r_start;
    assign mdIf.md_op     = r_op;
    assign mdIf.md_rdata1 = r_rdata1;
    assign mdIf.md_rdata2 = r_rdata2;

`ifdef MD_STALL_PERF_EN
    logic [31:0] r_stallCnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stallCnt <= '0;
        end else if (stall_e && (r_stallCnt != 32'hFFFF_FFFF)) begin
            r_stallCnt <= r_stallCnt + 32'd1;
        end
    end

    assign stall_cnt = r_stallCnt;
`endif

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
- E-stage issue controller directly upstream of the multiply/divide unit.
- Decodes the E-stage SPECIAL instruction and drives the unit's Start/Op/RData1/RData2, holding them for the full operation latency.
- Raises a pipeline stall for any HI/LO-dependent or mul/div instruction while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, cycles Start/Op are held for MULT/MULTU; must match the unit's count-to-done.
- DIV_CYCLES, 10, cycles held for DIV/DIVU.
- CNT_W, 4, width of the internal cycle counter; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- e_valid  in  1  E-stage holds a live instruction.
- e_kill  in  1  E-stage instruction is being flushed this cycle; suppresses issue.
- e_opcode  in  6  instruction bits [31:26].
- e_funct  in  6  instruction bits [5:0].
- e_rs_val  in  32  forwarded rs value.
- e_rt_val  in  32  forwarded rt value.
- md_busy  in  1  Busy from the mul/div unit.
- md_start  out  1  Start to the unit.
- md_op  out  4  Op to the unit: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO.
- md_rdata1  out  32  RData1 to the unit.
- md_rdata2  out  32  RData2 to the unit.
- stall_e  out  1  hold F/D/E, insert bubble into M.

Behaviour:
- Decode applies only when e_opcode == 0. Funct codes:
  - 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU: long ops.
  - 0x11 MTHI, 0x13 MTLO: move-to ops.
  - 0x10 MFHI, 0x12 MFLO: reads.
  - Everything else: non-MD.
- FSM states: IDLE, RUN_MUL, RUN_DIV. All outputs are registered except stall_e, which is combinational.
- Reset (async, reset == 0):
  - State IDLE, counter 0.
  - md_start 0, md_op 0, md_rdata1/2 0.
  - stall_e is 0 while reset is asserted.
- busy_any = (state != IDLE) | md_busy.
- stall_e = e_valid & ~e_kill & busy_any & (long op | move-to | read).
- Issue condition: e_valid & ~e_kill & ~busy_any.
- IDLE + issue + long op:
  - Next cycle: md_start = 1, md_op = code, md_rdata1 = rs, md_rdata2 = rt (latched).
  - Counter loads 1; state RUN_MUL or RUN_DIV.
- RUN_x:
  - md_start, md_op and md_rdata1/2 are held constant.
  - Counter increments each cycle.
  - When counter == MULT_CYCLES (RUN_MUL) or DIV_CYCLES (RUN_DIV): next cycle md_start = 0, md_op = 0, state IDLE, counter 0.
  - Start is therefore high for exactly N cycles.
- IDLE + issue + MTHI: one cycle with md_op = 5, md_rdata1 = rs, md_start = 0; then md_op returns to 0.
- IDLE + issue + MTLO: one cycle with md_op = 6, md_rdata2 = rs, md_start = 0; then md_op returns to 0.
- MFHI/MFLO: issue nothing; they only stall while busy_any.
- Back-to-back: a long op arriving the cycle the FSM returns to IDLE issues the following cycle. The minimum gap between Start pulses is one cycle with Start = 0, so the unit's counter restarts cleanly.
- e_kill in the same cycle as an issue candidate: no issue, no state change. e_kill has no effect once RUN_x has begun; a committed op runs to completion.
- Reset asserted mid-RUN: everything returns to reset values immediately. No partial Op is emitted after release.
- md_busy high while the FSM is in IDLE (unit/controller mismatch): stall continues until md_busy falls; nothing is issued.

Optional Feature:
- Macro: MD_STALL_PERF_EN.
- When defined:
  - Adds output stall_cnt (32 bits): counts cycles with stall_e = 1.
  - Saturates at 0xFFFFFFFF.
  - Cleared by reset.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package md_pkg: Op code constants (NONE..MTLO), SPECIAL funct constants, FSM state enum, default latency constants.
- Sub-module md_decode (combinational): maps opcode/funct to {is_long, is_move, is_read, op_code}.
- FSM, counter and output registers stay in md_issue_ctrl.

Test Plan:
- MULT issue: rs = 0xFFFFFFFE, rt = 3, unit idle.
  - md_start = 1 for exactly 5 cycles; md_op = 1; md_rdata1/2 = 0xFFFFFFFE / 3 held throughout.
  - Then md_op = 0 and the FSM is IDLE.
- DIV then MFLO next cycle: stall_e = 1 for 10 cycles; MFLO proceeds in the first cycle busy_any = 0.
- MTLO: rs = 0x12345678.
  - One cycle with md_op = 6, md_rdata2 = 0x12345678, md_start = 0.
  - No stall on the following instruction.
- DIVU presented with e_kill = 1: md_start stays 0, state IDLE, stall_e = 0.
- Reset pulled low at cycle 3 of DIV: md_start and md_op drop to 0 asynchronously. After release, a new MULTU issues normally with a 5-cycle Start.
- Back-to-back MULT, MULT: second Start rises exactly one Start = 0 cycle after the first ends; stall_e is asserted during the first op's 5 Start cycles.
